pong_game_ctrl: RTL and testbench

//  Game-flow controller for the two-player VGA pong design. Sits beside the pixel generator.

---
 rtl/pong_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game-flow controller for the two-player VGA pong design. Sits beside the
//   pixel generator. It sequences serve, play, point pause and game over, keeps
//   both scores, and drives the pixel generator's ball reset/enable and serve
//   direction. All timing is counted in video frames.
//
// Ports
//   i_clk100MHz   system clock, 100 MHz
//   i_reset       synchronous reset, active-low
//   i_start       debounced start button (level); rising edge detected here
//   i_frameTick   one-cycle pulse per video frame
//   i_missL       one-cycle pulse: ball passed left paddle (point to right)
//   i_missR       one-cycle pulse: ball passed right paddle (point to left)
//   o_ballReset   1 = hold ball at screen centre
//   o_ballEnable  1 = ball moves, 0 = ball frozen
//   o_serveDir    0 = next serve travels left, 1 = travels right
//   o_scoreL      left player score
//   o_scoreR      right player score
//   o_gameOver    1 while in OVER
//   o_winner      0 = left won, 1 = right won (valid while o_gameOver=1)
//   o_stateDbg    encoded current state
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 120,
   parameter int POINT_FRAMES = 60,
   parameter int SCORE_W      = 4
) (
   input  logic               i_clk100MHz,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_frameTick,
   input  logic               i_missL,
   input  logic               i_missR,
   output logic               o_ballReset,
   output logic               o_ballEnable,
   output logic               o_serveDir,
   output logic [SCORE_W-1:0] o_scoreL,
   output logic [SCORE_W-1:0] o_scoreR,
   output logic               o_gameOver,
   output logic               o_winner,
   output logic [2:0]         o_stateDbg
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_startPrev;

   state_t             w_nstate;
   logic [CNT_W-1:0]   w_ncnt;
   logic [SCORE_W-1:0] w_nscoreL;
   logic [SCORE_W-1:0] w_nscoreR;
   logic               w_ndir;
   logic               w_startEdge;

   assign w_startEdge = i_start & ~r_startPrev;

   // Next-state / next-data logic. Outputs are registered from these next
   // values so they line up with the state register.
   always_comb begin
      w_nstate  = r_state;
      w_ncnt    = r_cnt;
      w_nscoreL = o_scoreL;
      w_nscoreR = o_scoreR;
      w_ndir    = o_serveDir;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_startEdge) begin
               w_nscoreL = '0;
               w_nscoreR = '0;
               w_ndir    = 1'b1;
               w_nstate  = S_SERVE;
            end
         end
         S_SERVE: begin
            if (i_frameTick) begin
               if (r_cnt == SERVE_LAST) w_nstate = S_PLAY;
               else                     w_ncnt   = r_cnt + CNT_W'(1);
            end
         end
         S_PLAY: begin
            // missL has priority when both misses land in the same cycle
            if (i_missL) begin
               if (o_scoreR != WIN) w_nscoreR = o_scoreR + SCORE_W'(1);
               w_ndir   = 1'b0;
               w_nstate = S_POINT;
            end else if (i_missR) begin
               if (o_scoreL != WIN) w_nscoreL = o_scoreL + SCORE_W'(1);
               w_ndir   = 1'b1;
               w_nstate = S_POINT;
            end
         end
         S_POINT: begin
            if (i_frameTick) begin
               if (r_cnt == POINT_LAST) begin
                  if ((o_scoreL == WIN) || (o_scoreR == WIN)) w_nstate = S_OVER;
                  else                                         w_nstate = S_SERVE;
               end else begin
                  w_ncnt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_nstate = S_IDLE;
      endcase
      // Counter restarts on every state change, so the tick that causes an
      // entry never counts toward the new state's wait.
      if (w_nstate != r_state) w_ncnt = '0;
   end

   always_ff @(posedge i_clk100MHz) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_startPrev  <= 1'b1;  // a start held through reset must be re-pressed
         o_scoreL     <= '0;
         o_scoreR     <= '0;
         o_serveDir   <= 1'b1;
         o_ballReset  <= 1'b1;
         o_ballEnable <= 1'b0;
         o_gameOver   <= 1'b0;
         o_winner     <= 1'b0;
         o_stateDbg   <= 3'd0;
      end else begin
         r_state      <= w_nstate;
         r_cnt        <= w_ncnt;
         r_startPrev  <= i_start;
         o_scoreL     <= w_nscoreL;
         o_scoreR     <= w_nscoreR;
         o_serveDir   <= w_ndir;
         o_ballReset  <= (w_nstate == S_IDLE) || (w_nstate == S_SERVE) || (w_nstate == S_OVER);
         o_ballEnable <= (w_nstate == S_PLAY);
         o_gameOver   <= (w_nstate == S_OVER);
         o_winner     <= (w_nstate == S_OVER) && (w_nscoreR == WIN);
         o_stateDbg   <= w_nstate;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed bench for pong_game_ctrl with WIN_SCORE=2, SERVE_FRAMES=3,
//   POINT_FRAMES=2. Inputs change 1 ns after a rising edge; outputs are
//   checked at that same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n, start, tick, missL, missR;
   logic          ballReset, ballEnable, serveDir, gameOver, winner;
   logic [SW-1:0] scoreL, scoreR;
   logic [2:0]    stateDbg;

   int n_chk = 0;
   int n_bad = 0;

   pong_game_ctrl #(
      .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2), .SCORE_W(SW)
   ) dut (
      .i_clk100MHz (clk),
      .i_reset     (rst_n),
      .i_start     (start),
      .i_frameTick (tick),
      .i_missL     (missL),
      .i_missR     (missR),
      .o_ballReset (ballReset),
      .o_ballEnable(ballEnable),
      .o_serveDir  (serveDir),
      .o_scoreL    (scoreL),
      .o_scoreR    (scoreR),
      .o_gameOver  (gameOver),
      .o_winner    (winner),
      .o_stateDbg  (stateDbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; step(); tick = 1'b0;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0; step();
   endtask

   task automatic pulse_miss(input logic l, input logic r);
      missL = l; missR = r; step(); missL = 1'b0; missR = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; tick = 1'b0; missL = 1'b0; missR = 1'b0;
      step(); step();
      chk("rst_state", stateDbg, 0);
      chk("rst_ballReset", ballReset, 1);
      chk("rst_ballEnable", ballEnable, 0);
      chk("rst_serveDir", serveDir, 1);
      chk("rst_scores", {scoreL, scoreR}, 0);
      chk("rst_gameOver", gameOver, 0);
      chk("rst_winner", winner, 0);
      rst_n = 1'b1; step();

      // 1: start -> SERVE, 3 ticks -> PLAY
      start = 1'b1; step();
      chk("t1_serve", stateDbg, 1);
      chk("t1_ballReset", ballReset, 1);
      start = 1'b0; step();
      pulse_tick(2);
      chk("t1_still_serve", stateDbg, 1);
      pulse_tick(1);
      chk("t1_play", stateDbg, 2);
      chk("t1_ballEnable", ballEnable, 1);
      chk("t1_ballReset_low", ballReset, 0);

      // 2: missR -> left point
      pulse_miss(1'b0, 1'b1);
      chk("t2_scoreL", scoreL, 1);
      chk("t2_dir", serveDir, 1);
      chk("t2_point", stateDbg, 3);
      chk("t2_frozen", ballEnable, 0);
      pulse_tick(1);
      chk("t2_still_point", stateDbg, 3);
      pulse_tick(1);
      chk("t2_serve", stateDbg, 1);
      chk("t2_scores", {scoreL, scoreR}, 8'h10);

      // 3: reach 1-1, then 1-2 -> OVER, right wins
      pulse_tick(3);
      pulse_miss(1'b1, 1'b0);
      chk("t3_scoreR1", scoreR, 1);
      chk("t3_dir0", serveDir, 0);
      pulse_tick(2);
      chk("t3_serve_11", stateDbg, 1);
      pulse_tick(3);
      chk("t3_play", stateDbg, 2);
      pulse_miss(1'b1, 1'b0);
      chk("t3_scoreR2", scoreR, 2);
      pulse_tick(2);
      chk("t3_over", stateDbg, 4);
      chk("t3_gameOver", gameOver, 1);
      chk("t3_winner", winner, 1);
      chk("t3_ballReset", ballReset, 1);
      pulse_miss(1'b1, 1'b1);
      chk("t3_over_miss", {scoreL, scoreR}, 8'h12);
      start = 1'b1; step();
      chk("t3_restart", stateDbg, 1);
      chk("t3_clear", {scoreL, scoreR}, 0);
      chk("t3_dir1", serveDir, 1);
      chk("t3_gameOver_low", gameOver, 0);
      start = 1'b0; step();

      // 4: misses ignored outside PLAY; simultaneous misses -> missL wins
      pulse_miss(1'b1, 1'b1);
      chk("t4_serve_miss", {scoreL, scoreR}, 0);
      chk("t4_serve_hold", stateDbg, 1);
      pulse_tick(3);
      pulse_miss(1'b1, 1'b1);
      chk("t4_both", {scoreL, scoreR}, 8'h01);
      chk("t4_both_dir", serveDir, 0);
      pulse_miss(1'b0, 1'b1);
      chk("t4_point_miss", {scoreL, scoreR}, 8'h01);
      pulse_tick(2);
      // left comes back to win 2-1
      pulse_tick(3);
      pulse_miss(1'b0, 1'b1);
      pulse_tick(2);
      pulse_tick(3);
      pulse_miss(1'b0, 1'b1);
      chk("t4_left_score", {scoreL, scoreR}, 8'h21);
      pulse_tick(2);
      chk("t4_over", stateDbg, 4);
      chk("t4_winner_left", winner, 0);

      // 5: start held through reset must be released first
      start = 1'b1; rst_n = 1'b0; step();
      chk("t5_rst_state", stateDbg, 0);
      chk("t5_rst_scores", {scoreL, scoreR}, 0);
      chk("t5_rst_gameOver", gameOver, 0);
      rst_n = 1'b1; step(); step();
      chk("t5_held_idle", stateDbg, 0);
      pulse_miss(1'b1, 1'b0);
      chk("t5_idle_miss", scoreR, 0);
      start = 1'b0; step();
      chk("t5_released", stateDbg, 0);
      start = 1'b1; step();
      chk("t5_serve", stateDbg, 1);
      start = 1'b0; step();

      // 6: reset mid-count, then a full serve wait is needed
      pulse_tick(2);
      rst_n = 1'b0; step();
      chk("t6_rst_state", stateDbg, 0);
      chk("t6_rst_ballReset", ballReset, 1);
      chk("t6_rst_ballEnable", ballEnable, 0);
      chk("t6_rst_dir", serveDir, 1);
      rst_n = 1'b1; step();
      pulse_start();
      pulse_tick(2);
      chk("t6_two_ticks", stateDbg, 1);
      pulse_tick(1);
      chk("t6_play", stateDbg, 2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
